// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 serial receiver with self-timed bit sampling re-centred on each start edge.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);
  localparam logic [19:0] HALF_M1 = 20'(CLKS_PER_BIT / 2 - 1);
  localparam logic [19:0] BIT_M1 = 20'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, rx_d, fall;
  logic [19:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, data_n;
  logic valid_n, ferr_n;
  // synchronizer and edge-history flops idle high so reset never looks like a start edge
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) {rx_m, rx_s, rx_d} <= 3'b111;
    else {rx_m, rx_s, rx_d} <= {i_rx, rx_m, rx_s};
  assign fall = rx_d & ~rx_s;
  assign o_busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 20'd1;
    idx_n = idx;
    sh_n = sh;
    data_n = o_data;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = fall ? START : IDLE;
      end
      START: if (cnt == HALF_M1) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == BIT_M1) begin
        cnt_n = '0;
        sh_n = {rx_s, sh[7:1]};
        idx_n = idx + 3'd1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (cnt == BIT_M1) begin
        cnt_n = '0;
        state_n = IDLE;
        valid_n = rx_s;
        ferr_n = ~rx_s;
        data_n = rx_s ? sh : o_data;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      o_data <= '0;
      o_valid <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      o_data <= data_n;
      o_valid <= valid_n;
      o_frame_err <= ferr_n;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at 16 clocks/bit with hand-computed bytes and pulse timing.
module tb_uart_rx;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] data;
  logic valid, ferr, busy;
  int cyc = 0, t0 = 0, n_chk = 0, n_fail = 0, ferr_n = 0, both_n = 0;
  logic [7:0] vq[$];
  int vt[$];

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx(rx),
    .o_data(data), .o_valid(valid), .o_frame_err(ferr), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid) begin
      vq.push_back(data);
      vt.push_back(cyc);
    end
    if (ferr) ferr_n++;
    if (valid && ferr) both_n++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear();
    vq.delete();
    vt.delete();
    ferr_n = 0;
  endtask

  task automatic do_reset();
    rx = 1'b1;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
  endtask

  // caller must be at a negedge; bit j starts at negedge cyc == t0 + cpb*j
  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      idle(cpb);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_busy", busy, 0);
    idle(200);
    chk("idle_nvalid", vq.size(), 0);
    chk("idle_nferr", ferr_n, 0);
    chk("idle_busy", busy, 0);

    // pulse lands 3 sync/edge clocks + 8 + 9*16 after the pin falls
    clear();
    send_byte(8'hA5, 16, 1'b1);
    idle(20);
    chk("a5_nvalid", vq.size(), 1);
    chk("a5_data", vq.size() > 0 ? vq[0] : -1, 8'hA5);
    chk("a5_time", vq.size() > 0 ? vt[0] - t0 : -1, 155);
    chk("a5_nferr", ferr_n, 0);

    clear();
    send_byte(8'h00, 16, 1'b1);
    send_byte(8'hFF, 16, 1'b1);
    idle(20);
    send_byte(8'h3C, 16, 1'b1);
    idle(20);
    chk("b2b_nvalid", vq.size(), 3);
    chk("b2b_d0", vq.size() > 0 ? vq[0] : -1, 8'h00);
    chk("b2b_d1", vq.size() > 1 ? vq[1] : -1, 8'hFF);
    chk("b2b_d2", vq.size() > 2 ? vq[2] : -1, 8'h3C);
    chk("b2b_gap", vq.size() > 1 ? vt[1] - vt[0] : -1, 160);

    clear();
    rx = 1'b0;
    idle(4);
    chk("glitch_busy", busy, 1);
    rx = 1'b1;
    idle(30);
    chk("glitch_idle", busy, 0);
    chk("glitch_npulse", vq.size() + ferr_n, 0);

    do_reset();
    clear();
    send_byte(8'h55, 16, 1'b0);
    idle(64);
    chk("ferr_count", ferr_n, 1);
    chk("ferr_data", data, 8'h00);
    chk("break_busy", busy, 0);
    rx = 1'b1;
    idle(20);
    send_byte(8'h81, 16, 1'b1);
    idle(20);
    chk("rearm_nvalid", vq.size(), 1);
    chk("rearm_data", vq.size() > 0 ? vq[0] : -1, 8'h81);
    chk("never_both", both_n, 0);

    // F3 keeps the line high from data bit 4 onward, so releasing reset sees no edge
    clear();
    fork
      send_byte(8'hF3, 16, 1'b1);
      begin
        idle(86);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
      end
    join
    idle(20);
    send_byte(8'h7E, 16, 1'b1);
    idle(20);
    chk("midrst_nvalid", vq.size(), 1);
    chk("midrst_data", vq.size() > 0 ? vq[0] : -1, 8'h7E);
    chk("midrst_nferr", ferr_n, 0);

    clear();
    send_byte(8'hC3, 15, 1'b1);
    idle(30);
    chk("baud15_nvalid", vq.size(), 1);
    chk("baud15_data", vq.size() > 0 ? vq[0] : -1, 8'hC3);
    clear();
    send_byte(8'hC3, 17, 1'b1);
    idle(30);
    chk("baud17_nvalid", vq.size(), 1);
    chk("baud17_data", vq.size() > 0 ? vq[0] : -1, 8'hC3);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
